// File: rtl/tt_checker_pkg.sv
// Shared definitions for truth_table_checker.
// Contents: sweep FSM state encoding and default values for the top-level parameters.
package tt_checker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWait,
    StSample,
    StDone
  } state_e;

  localparam int unsigned N_IN_DEF     = 4;
  localparam int unsigned SETTLE_DEF   = 4;
  // Default table is a 4-input AND: only vector 4'b1111 expects a 1.
  localparam logic [15:0] EXPECTED_DEF = 16'h8000;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long a DUT input vector is held before sampling.
// Ports:
//   clk_i       clock, rising edge
//   reset_i     synchronous active-high reset (clears the count)
//   load_i      load load_val_i into the counter (wins over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one; a count already at zero stays at zero
//   zero_o      count is zero
module settle_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// On-board truth-table checker: sweeps every input vector of an N_IN-input combinational
// DUT, holds each vector for SETTLE cycles, samples the DUT output and compares it with
// the EXPECTED table. Each vector costs SETTLE+2 cycles (apply, SETTLE waits, sample).
// Optional feature macro: MISMATCH_LOG_EN adds first_fail/first_fail_v/fail_map.
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset; aborts any sweep
//   start         one-cycle pulse, starts a sweep from idle or done (ignored while busy)
//   dut_out       DUT response, read only in the sample state
//   dut_in        vector driven to the DUT; 0 when not sweeping
//   busy          sweep in progress
//   done          sweep finished; held until next start or reset
//   pass          done with zero mismatches
//   err_count     number of mismatching vectors in the last sweep
//   first_fail    (MISMATCH_LOG_EN) index of the first mismatching vector
//   first_fail_v  (MISMATCH_LOG_EN) first_fail holds a captured index
//   fail_map      (MISMATCH_LOG_EN) bit i set if vector i mismatched
module truth_table_checker
  import tt_checker_pkg::*;
#(
  parameter int unsigned          N_IN     = N_IN_DEF,
  parameter logic [2**N_IN-1:0]   EXPECTED = EXPECTED_DEF,
  parameter int unsigned          SETTLE   = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count
`ifdef MISMATCH_LOG_EN
  ,
  output logic [N_IN-1:0]   first_fail,
  output logic              first_fail_v,
  output logic [2**N_IN-1:0] fail_map
`endif
);

  localparam int unsigned    TimerW = $clog2(SETTLE) + 1;
  localparam logic [N_IN-1:0] IdxMax = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [N_IN:0]     err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              start_sweep;
  logic              mismatch;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_zero;

  settle_timer #(
    .Width (TimerW)
  ) u_settle_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (timer_load),
    .load_val_i (TimerW'(SETTLE - 1)),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  assign start_sweep = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    mismatch   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_sweep) begin
          state_d = StApply;
          idx_d   = '0;
          err_d   = '0;
        end
      end
      StApply: begin
        timer_load = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (timer_zero) begin
          state_d = StSample;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StSample: begin
        mismatch = (dut_out != EXPECTED[idx_q]);
        if (mismatch) begin
          err_d = err_q + (N_IN + 1)'(1);
        end
        if (idx_q == IdxMax) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state values so they line up with state_q.
    busy_d   = (state_d == StApply) || (state_d == StWait) || (state_d == StSample);
    dut_in_d = busy_d ? idx_d : '0;
    done_d   = (state_d == StDone);
    pass_d   = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dut_in_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef MISMATCH_LOG_EN
  logic [N_IN-1:0]    first_fail_q, first_fail_d;
  logic               first_fail_v_q, first_fail_v_d;
  logic [2**N_IN-1:0] fail_map_q, fail_map_d;

  always_comb begin
    first_fail_d   = first_fail_q;
    first_fail_v_d = first_fail_v_q;
    fail_map_d     = fail_map_q;
    if (start_sweep) begin
      first_fail_d   = '0;
      first_fail_v_d = 1'b0;
      fail_map_d     = '0;
    end else if (mismatch) begin
      // Only the first mismatch of a sweep is captured.
      if (!first_fail_v_q) begin
        first_fail_d   = idx_q;
        first_fail_v_d = 1'b1;
      end
      fail_map_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_fail_q   <= '0;
      first_fail_v_q <= 1'b0;
      fail_map_q     <= '0;
    end else begin
      first_fail_q   <= first_fail_d;
      first_fail_v_q <= first_fail_v_d;
      fail_map_q     <= fail_map_d;
    end
  end

  assign first_fail   = first_fail_q;
  assign first_fail_v = first_fail_v_q;
  assign fail_map     = fail_map_q;
`endif

endmodule
